// File: rtl/lift_pkg.sv
// lift_pkg: shared call, move and scheduler-state encodings for the lift call scheduler.
package lift_pkg;
   typedef enum logic [2:0] {C_NONE = 3'd0, C_1U, C_2U, C_3U, C_2D, C_3D, C_4D} call_t;
   typedef enum logic [1:0] {STAY = 2'b00, UP = 2'b01, DOWN = 2'b10} move_t;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;
   function automatic logic [2:0] low_code(input logic [5:0] v);
      low_code = C_NONE;
      for (int i = 5; i >= 0; i--)
         if (v[i]) low_code = 3'(i + 1);
   endfunction
endpackage

// File: rtl/lift_call_fifo.sv
// lift_call_fifo: DEPTH-entry FIFO of 3-bit call codes with full/empty/count.
module lift_call_fifo #(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [2:0]       din,
   output logic [2:0]       dout,
   output logic             full,
   output logic             empty,
   output logic [DEPTH-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [2:0]    mem [DEPTH];
   logic [AW-1:0] wp, rp;
   always_ff @(posedge clk)
      if (push) mem[wp] <= din;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         wp    <= push ? wp + AW'(1) : wp;
         rp    <= pop ? rp + AW'(1) : rp;
         count <= push && !pop ? count + DEPTH'(1) : !push && pop ? count - DEPTH'(1) : count;
      end
   assign dout  = mem[rp];
   assign full  = count == DEPTH'(DEPTH);
   assign empty = count == '0;
endmodule

// File: rtl/lift_call_scheduler.sv
// lift_call_scheduler: queues hall calls in arrival order and feeds them one at a
// time to the lift FSM, with duplicate suppression, floor tracking and a stuck-request timeout.
module lift_call_scheduler
   import lift_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] call_btn,
   input  logic       fsm_done,
   input  logic [1:0] fsm_move,
   output logic [2:0] fsm_in,
   output logic       q_empty,
   output logic [5:0] pending,
   output logic [1:0] cur_floor,
   output logic       timeout
);
   state_t           state;
   logic [5:0]       latch, qbits, push_oh, pop_oh;
   logic [7:0]       timer;
   logic [2:0]       head;
   logic [DEPTH-1:0] count;
   logic             push, pop, done_pop, full, empty;
   assign pending  = latch | qbits;
   assign push     = |latch && !full;
   assign push_oh  = push ? latch & (~latch + 6'd1) : 6'd0;
   // fsm_done is ignored on the first BUSY cycle (timer still 0)
   assign done_pop = fsm_done && timer != 8'd0;
   assign pop      = state == S_BUSY && !empty && (done_pop || timer == 8'(TIMEOUT - 1));
   assign pop_oh   = pop ? 6'd1 << (head - 3'd1) : 6'd0;
   lift_call_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (low_code(latch)),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= S_IDLE;
         latch     <= '0;
         qbits     <= '0;
         timer     <= '0;
         fsm_in    <= C_NONE;
         q_empty   <= 1'b1;
         cur_floor <= '0;
         timeout   <= 1'b0;
      end else begin
         latch     <= (latch & ~push_oh) | (call_btn & ~pending);
         qbits     <= (qbits | push_oh) & ~pop_oh;
         cur_floor <= fsm_move == UP && cur_floor != 2'd3 ? cur_floor + 2'd1 :
                      fsm_move == DOWN && cur_floor != 2'd0 ? cur_floor - 2'd1 : cur_floor;
         timeout   <= 1'b0;
         case (state)
            S_IDLE:
               if (count != '0) begin
                  state   <= S_ISSUE;
                  fsm_in  <= head;
                  q_empty <= 1'b0;
               end
            S_ISSUE: begin
               state  <= S_BUSY;
               fsm_in <= C_NONE;
               timer  <= '0;
            end
            S_BUSY:
               if (pop) begin
                  state   <= S_IDLE;
                  q_empty <= 1'b1;
                  timeout <= !done_pop;
               end else
                  timer <= timer + 8'd1;
            default: state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_lift_call_scheduler.sv
// tb_lift_call_scheduler: directed checks of capture, ordering, full-FIFO hold, timeout, floor tracking and reset.
module tb_lift_call_scheduler;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] call_btn = '0;
   logic       fsm_done = 1'b0;
   logic [1:0] fsm_move = 2'b00;
   logic [2:0] fsm_in;
   logic       q_empty;
   logic [5:0] pending;
   logic [1:0] cur_floor;
   logic       timeout;
   int         errors = 0;
   int         checks = 0;
   lift_call_scheduler #(.DEPTH(4), .TIMEOUT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .call_btn  (call_btn),
      .fsm_done  (fsm_done),
      .fsm_move  (fsm_move),
      .fsm_in    (fsm_in),
      .q_empty   (q_empty),
      .pending   (pending),
      .cur_floor (cur_floor),
      .timeout   (timeout)
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic reset_dut;
      call_btn = '0;
      fsm_done = 1'b0;
      fsm_move = 2'b00;
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
   endtask
   task automatic serve(input logic [2:0] code);
      int n = 0;
      while (fsm_in == 3'd0 && n < 40) begin
         tick;
         n++;
      end
      chk("issue_code", fsm_in, code);
      tick;
      tick;
      fsm_done = 1'b1;
      tick;
      fsm_done = 1'b0;
   endtask
   initial begin
      int up_exp[5] = '{1, 2, 3, 3, 3};
      int dn_exp[4] = '{2, 1, 0, 0};
      // idle after reset
      reset_dut;
      for (int i = 0; i < 6; i++) begin
         chk("idle_fsm_in", fsm_in, 0);
         chk("idle_q_empty", q_empty, 1);
         chk("idle_pending", pending, 0);
         chk("idle_floor", cur_floor, 0);
         tick;
      end
      // single call latency and done handling
      reset_dut;
      call_btn = 6'b000010;
      tick;
      call_btn = '0;
      chk("t2_pend_c1", pending, 6'h02);
      tick;
      chk("t2_fsm_in_c2", fsm_in, 0);
      tick;
      chk("t2_fsm_in_c3", fsm_in, 2);
      chk("t2_q_empty_c3", q_empty, 0);
      tick;
      chk("t2_fsm_in_c4", fsm_in, 0);
      chk("t2_q_empty_c4", q_empty, 0);
      tick;
      tick;
      fsm_done = 1'b1;
      tick;
      fsm_done = 1'b0;
      chk("t2_pend_c7", pending, 0);
      chk("t2_q_empty_c7", q_empty, 1);
      // multi-press ordering and duplicate suppression
      reset_dut;
      call_btn = 6'b100101;
      tick;
      call_btn = '0;
      chk("t3_pend", pending, 6'h25);
      tick;
      tick;
      chk("t3_first", fsm_in, 1);
      call_btn = 6'b000001;
      tick;
      call_btn = '0;
      chk("t3_pend_dup", pending, 6'h25);
      tick;
      fsm_done = 1'b1;
      tick;
      fsm_done = 1'b0;
      serve(3);
      serve(6);
      for (int i = 0; i < 10; i++) tick;
      chk("t3_q_empty_end", q_empty, 1);
      chk("t3_pend_end", pending, 0);
      // full FIFO: two calls wait in the latch
      reset_dut;
      call_btn = 6'h3F;
      tick;
      call_btn = '0;
      chk("t4_pend_c1", pending, 6'h3F);
      tick;
      chk("t4_pend_c2", pending, 6'h3F);
      serve(1);
      chk("t4_pend_after1", pending, 6'h3E);
      serve(2);
      serve(3);
      serve(4);
      serve(5);
      serve(6);
      tick;
      chk("t4_pend_end", pending, 0);
      chk("t4_q_empty_end", q_empty, 1);
      // done on first BUSY cycle is ignored
      reset_dut;
      call_btn = 6'b001000;
      tick;
      call_btn = '0;
      tick;
      tick;
      tick;
      fsm_done = 1'b1;
      tick;
      fsm_done = 1'b0;
      chk("t5b_q_empty", q_empty, 0);
      chk("t5b_pend", pending, 6'h08);
      fsm_done = 1'b1;
      tick;
      fsm_done = 1'b0;
      chk("t5b_q_empty_pop", q_empty, 1);
      chk("t5b_timeout", timeout, 0);
      // timeout after 16 BUSY cycles
      reset_dut;
      call_btn = 6'b000100;
      tick;
      call_btn = '0;
      for (int i = 0; i < 18; i++) tick;
      chk("t5_to_c19", timeout, 0);
      chk("t5_q_empty_c19", q_empty, 0);
      tick;
      chk("t5_to_c20", timeout, 1);
      chk("t5_q_empty_c20", q_empty, 1);
      chk("t5_pend_c20", pending, 0);
      tick;
      chk("t5_to_c21", timeout, 0);
      // floor tracking with saturation
      reset_dut;
      fsm_move = 2'b01;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("t6_up", cur_floor, up_exp[i]);
      end
      fsm_move = 2'b10;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("t6_down", cur_floor, dn_exp[i]);
      end
      fsm_move = 2'b01;
      tick;
      fsm_move = 2'b00;
      chk("t6_floor1", cur_floor, 1);
      // async reset mid-BUSY
      call_btn = 6'b100000;
      tick;
      call_btn = '0;
      tick;
      tick;
      tick;
      chk("t6_busy_q_empty", q_empty, 0);
      chk("t6_busy_pend", pending, 6'h20);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_fsm_in", fsm_in, 0);
      chk("t6_rst_q_empty", q_empty, 1);
      chk("t6_rst_pend", pending, 0);
      chk("t6_rst_floor", cur_floor, 0);
      chk("t6_rst_timeout", timeout, 0);
      tick;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) tick;
      chk("t6_lost_q_empty", q_empty, 1);
      chk("t6_lost_fsm_in", fsm_in, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
